// File: rtl/comp_deser_if.sv
// -----------------------------------------------------------------------------
// comp_deser_if
//
// Bundles the serial receive side and the parallel result side of the
// serial two's-complement deserialiser.
//
//   x          serial data bit, LSB first
//   x_valid    qualifies x; low means the link is stalled
//   start      marks the LSB of a frame (meaningful only with x_valid)
//   mag        unsigned magnitude of the last completed frame
//   sign       1 = last completed frame was negative
//   out_valid  one-cycle pulse when mag/sign update
//   busy       1 while a frame is partially received
//   frame_err  one-cycle pulse when a frame is abandoned by a new start
//              (present only with COMP_DESER_FRAME_ERR_EN defined)
//
// Modports: master = serial link / result consumer, slave = deserialiser.
// -----------------------------------------------------------------------------
interface comp_deser_if #(
    parameter int WIDTH = 8
);
    logic             x;
    logic             x_valid;
    logic             start;
    logic [WIDTH-1:0] mag;
    logic             sign;
    logic             out_valid;
    logic             busy;
`ifdef COMP_DESER_FRAME_ERR_EN
    logic             frame_err;
`endif

    modport master (
        output x, x_valid, start,
        input  mag, sign, out_valid, busy
`ifdef COMP_DESER_FRAME_ERR_EN
        , input frame_err
`endif
    );

    modport slave (
        input  x, x_valid, start,
        output mag, sign, out_valid, busy
`ifdef COMP_DESER_FRAME_ERR_EN
        , output frame_err
`endif
    );
endinterface

// File: rtl/comp_deser.sv
// -----------------------------------------------------------------------------
// comp_deser
//
// Receive end of the serial two's-complement link. Collects a framed,
// LSB-first two's-complement word one accepted bit at a time and presents it
// as a sign bit plus unsigned magnitude. The magnitude of a negative word is
// built on the fly with the serial complement rule: bits pass unchanged up to
// and including the first 1, every later bit is inverted.
//
// Parameters:
//   WIDTH  bits per frame including the sign (MSB, received last), 2..32.
//          Must match the WIDTH of the connected comp_deser_if.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    comp_deser_if.slave (x, x_valid, start in; mag, sign,
//          out_valid, busy, optional frame_err out)
//
// Optional feature (macro COMP_DESER_FRAME_ERR_EN):
//   defined   - a start while busy abandons the partial frame, pulses
//               frame_err and begins a new frame with that bit.
//   undefined - a start while busy is treated as an ordinary data bit.
// -----------------------------------------------------------------------------
module comp_deser #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    comp_deser_if.slave   bus
);

    localparam int              CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef COMP_DESER_FRAME_ERR_EN
    localparam bit RESTART_EN = 1'b1;
`else
    localparam bit RESTART_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // no frame in progress
        PASS = 2'd1,   // frame active, no 1 seen yet
        INV  = 2'd2    // frame active, a 1 has been seen
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic [WIDTH-1:0] cpl_q, cpl_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic             sign_q, sign_d;
    logic             out_valid_q, out_valid_d;
`ifdef COMP_DESER_FRAME_ERR_EN
    logic             frame_err_q, frame_err_d;
`endif

    // Bit classification for the current edge.
    logic             frame_start;   // accepted bit opens a new frame
    logic             data_bit;      // accepted bit belongs to the open frame
    logic             last_bit;      // data_bit that is the MSB
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] cpl_next;

    always_comb begin
        frame_start = bus.x_valid && bus.start && ((state_q == IDLE) || RESTART_EN);
        data_bit    = bus.x_valid && (state_q != IDLE) && !frame_start;
        last_bit    = data_bit && (cnt_q == LAST);

        // Frame registers with the incoming bit merged at the current index.
        raw_next        = raw_q;
        raw_next[cnt_q] = bus.x;
        cpl_next        = cpl_q;
        cpl_next[cnt_q] = (state_q == INV) ? ~bus.x : bus.x;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: state_d gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (frame_start) begin
            state_d = bus.x ? INV : PASS;
        end else if (last_bit) begin
            state_d = IDLE;
        end else if (data_bit && (state_q == PASS) && bus.x) begin
            state_d = INV;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bus.busy = (state_q != IDLE);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        raw_d       = raw_q;
        cpl_d       = cpl_q;
        mag_d       = mag_q;
        sign_d      = sign_q;
        out_valid_d = 1'b0;
`ifdef COMP_DESER_FRAME_ERR_EN
        frame_err_d = frame_start && (state_q != IDLE);
`endif
        if (frame_start) begin
            // The first bit always passes: complementing starts after a 1.
            cnt_d = CNT_W'(1);
            raw_d = {{(WIDTH-1){1'b0}}, bus.x};
            cpl_d = {{(WIDTH-1){1'b0}}, bus.x};
        end else if (data_bit) begin
            raw_d = raw_next;
            cpl_d = cpl_next;
            if (last_bit) begin
                cnt_d       = '0;
                // The MSB just received selects raw (positive) or
                // complemented (negative) bits as the magnitude.
                mag_d       = bus.x ? cpl_next : raw_next;
                sign_d      = bus.x;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: every register here, including the frame shift registers, is
    // reset so a frame cut short by reset leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            raw_q       <= '0;
            cpl_q       <= '0;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef COMP_DESER_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            raw_q       <= raw_d;
            cpl_q       <= cpl_d;
            mag_q       <= mag_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
`ifdef COMP_DESER_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign bus.mag       = mag_q;
    assign bus.sign      = sign_q;
    assign bus.out_valid = out_valid_q;
`ifdef COMP_DESER_FRAME_ERR_EN
    assign bus.frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_comp_deser.sv
// -----------------------------------------------------------------------------
// tb_comp_deser
//
// Self-checking bench for comp_deser (WIDTH=8). A reference model collects
// accepted bits into a word and derives sign and magnitude arithmetically
// from the two's-complement value. Honours COMP_DESER_FRAME_ERR_EN.
// -----------------------------------------------------------------------------
module tb_comp_deser;

    localparam int W = 8;

`ifdef COMP_DESER_FRAME_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk;
    logic reset;

    comp_deser_if #(.WIDTH(W)) bus ();

    comp_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    int cyc;

    // Reference model state
    bit           m_busy;
    int           m_n;
    logic [W-1:0] m_word;
    bit           m_ov;
    bit           m_err;
    bit           m_sign;
    logic [W-1:0] m_mag;

    task automatic model_reset();
        m_busy = 1'b0;
        m_n    = 0;
        m_word = '0;
        m_ov   = 1'b0;
        m_err  = 1'b0;
        m_sign = 1'b0;
        m_mag  = '0;
    endtask

    // One clock edge of the model.
    task automatic model_step(input bit x, input bit s, input bit v);
        longint val;
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (s && (!m_busy || ERR_EN)) begin
                m_err     = m_busy;
                m_busy    = 1'b1;
                m_word    = '0;
                m_word[0] = x;
                m_n       = 1;
            end else if (m_busy) begin
                m_word[m_n] = x;
                m_n++;
                if (m_n == W) begin
                    val = longint'(m_word);
                    if (m_word[W-1]) val = val - (longint'(1) << W);
                    m_sign = (val < 0);
                    m_mag  = W'((val < 0) ? -val : val);
                    m_ov   = 1'b1;
                    m_busy = 1'b0;
                    m_n    = 0;
                end
            end
        end
    endtask

    // Drive one cycle from a falling edge; returns at the next falling edge.
    task automatic drive(input bit x, input bit s, input bit v);
        bus.x       = x;
        bus.start   = s;
        bus.x_valid = v;
        @(posedge clk);
        model_step(x, s, v);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.x = 1'b0; bus.start = 1'b0; bus.x_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_state: got ov=%b busy=%b sign=%b mag=%0d, want all 0",
                     bus.out_valid, bus.busy, bus.sign, bus.mag);
        end
`ifdef COMP_DESER_FRAME_ERR_EN
        n_cmp++;
        if (bus.frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_frame_err: got %b want 0", bus.frame_err);
        end
`endif
    endtask

    // Plan 1: +5
    task automatic test_basic();
        logic [W-1:0] w;
        w = 8'd5;
        for (int i = 0; i < W + 1; i++) begin
            if (i < W) drive(w[i], i == 0, 1'b1);
            else       drive(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                n_bad++;
                $display("FAIL basic step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                         i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
            end
        end
        n_cmp++;
        if ({bus.sign, bus.mag} !== {1'b0, 8'd5}) begin
            n_bad++;
            $display("FAIL basic_plus5: got sign=%b mag=%0d, want sign=0 mag=5", bus.sign, bus.mag);
        end
    endtask

    // Plan 2: -5 then 0 with start in the out_valid cycle
    task automatic test_back_to_back();
        logic [W-1:0] w [2];
        w[0] = 8'hFB;
        w[1] = 8'h00;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < W; i++) begin
                drive(w[f][i], i == 0, 1'b1);
                n_cmp++;
                if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                    n_bad++;
                    $display("FAIL b2b f%0d step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                             f, i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
                end
            end
            n_cmp++;
            if ({bus.out_valid, bus.sign, bus.mag} !== ((f == 0) ? {1'b1, 1'b1, 8'd5} : {1'b1, 1'b0, 8'd0})) begin
                n_bad++;
                $display("FAIL b2b_result f%0d: got ov=%b sign=%b mag=%0d", f, bus.out_valid, bus.sign, bus.mag);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    // Plan 3: -128 and +127
    task automatic test_extremes();
        logic [W-1:0] w [2];
        w[0] = 8'h80;
        w[1] = 8'h7F;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < W; i++) begin
                drive(w[f][i], i == 0, 1'b1);
                n_cmp++;
                if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                    n_bad++;
                    $display("FAIL extremes f%0d step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                             f, i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
                end
            end
            n_cmp++;
            if ({bus.sign, bus.mag} !== ((f == 0) ? {1'b1, 8'd128} : {1'b0, 8'd127})) begin
                n_bad++;
                $display("FAIL extremes_result f%0d: got sign=%b mag=%0d", f, bus.sign, bus.mag);
            end
            drive(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Plan 4: -3 with a 3-cycle stall after bit 2
    task automatic test_stall();
        logic [W-1:0] w;
        int           pulse_at;
        w        = 8'hFD;
        pulse_at = -1;
        for (int i = 0, b = 0; i < W + 4; i++) begin
            if (i >= 2 && i < 5) begin
                drive(1'b0, 1'b0, 1'b0);
            end else if (b < W) begin
                drive(w[b], b == 0, 1'b1);
                b++;
            end else begin
                drive(1'b0, 1'b0, 1'b0);
            end
            if (bus.out_valid === 1'b1 && pulse_at < 0) pulse_at = i;
            n_cmp++;
            if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                n_bad++;
                $display("FAIL stall step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                         i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
            end
        end
        n_cmp++;
        if (pulse_at !== 10 || {bus.sign, bus.mag} !== {1'b1, 8'd3}) begin
            n_bad++;
            $display("FAIL stall_result: got pulse step %0d sign=%b mag=%0d, want step 10 sign=1 mag=3",
                     pulse_at, bus.sign, bus.mag);
        end
    endtask

    // Plan 5: reset mid-frame, then +9
    task automatic test_mid_reset();
        logic [W-1:0] w;
        int           pulses;
        w = 8'hA6;
        for (int i = 0; i < 4; i++) drive(w[i], i == 0, 1'b1);
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL midreset_zero: got ov=%b busy=%b sign=%b mag=%0d, want all 0",
                     bus.out_valid, bus.busy, bus.sign, bus.mag);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        w      = 8'd9;
        pulses = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (i < W) drive(w[i], i == 0, 1'b1);
            else       drive(1'b0, 1'b0, 1'b0);
            if (bus.out_valid === 1'b1) pulses++;
            n_cmp++;
            if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                n_bad++;
                $display("FAIL midreset step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                         i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
            end
        end
        n_cmp++;
        if (pulses !== 1 || {bus.sign, bus.mag} !== {1'b0, 8'd9}) begin
            n_bad++;
            $display("FAIL midreset_result: got %0d pulses sign=%b mag=%0d, want 1 pulse sign=0 mag=9",
                     pulses, bus.sign, bus.mag);
        end
    endtask

    // Plan 6: 4 bits of a frame, then start with 8 bits of -1
    task automatic test_restart();
        logic [3:0]   head;
        logic [W-1:0] w;
        int           errs;
        head = 4'b0110;   // LSB first: 0,1,1,0
        w    = 8'hFF;
        errs = 0;
        for (int i = 0; i < 4 + W + 1; i++) begin
            if (i < 4)          drive(head[i], i == 0, 1'b1);
            else if (i < 4 + W) drive(w[i-4], i == 4, 1'b1);
            else                drive(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                n_bad++;
                $display("FAIL restart step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                         i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
            end
`ifdef COMP_DESER_FRAME_ERR_EN
            if (bus.frame_err === 1'b1) errs++;
            n_cmp++;
            if (bus.frame_err !== m_err) begin
                n_bad++;
                $display("FAIL restart_frame_err step %0d: got %b want %b", i, bus.frame_err, m_err);
            end
`endif
        end
        n_cmp++;
        if (ERR_EN) begin
            if (errs !== 1 || {bus.sign, bus.mag} !== {1'b1, 8'd1}) begin
                n_bad++;
                $display("FAIL restart_result: got %0d err pulses sign=%b mag=%0d, want 1 pulse sign=1 mag=1",
                         errs, bus.sign, bus.mag);
            end
        end else begin
            // Word 0,1,1,0,1,1,1,1 = 0xF6 = -10
            if ({bus.sign, bus.mag} !== {1'b1, 8'd10}) begin
                n_bad++;
                $display("FAIL restart_result: got sign=%b mag=%0d, want sign=1 mag=10", bus.sign, bus.mag);
            end
        end
    endtask

    // Random bits, stalls and starts (including starts while busy).
    task automatic test_random();
        bit x, s, v;
        for (int i = 0; i < 600; i++) begin
            x = 1'($urandom_range(0, 1));
            v = ($urandom_range(0, 9) < 7);
            s = m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            drive(x, s, v);
            n_cmp++;
            if ({bus.out_valid, bus.busy, bus.sign, bus.mag} !== {m_ov, m_busy, m_sign, m_mag}) begin
                n_bad++;
                $display("FAIL random step %0d: got ov=%b busy=%b sign=%b mag=%0d, want ov=%b busy=%b sign=%b mag=%0d",
                         i, bus.out_valid, bus.busy, bus.sign, bus.mag, m_ov, m_busy, m_sign, m_mag);
            end
`ifdef COMP_DESER_FRAME_ERR_EN
            n_cmp++;
            if (bus.frame_err !== m_err) begin
                n_bad++;
                $display("FAIL random_frame_err step %0d: got %b want %b", i, bus.frame_err, m_err);
            end
`endif
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        cyc         = 0;
        reset       = 1'b1;
        bus.x       = 1'b0;
        bus.start   = 1'b0;
        bus.x_valid = 1'b0;
        model_reset();

        test_reset();
        test_basic();
        test_back_to_back();
        test_extremes();
        test_stall();
        test_mid_reset();
        do_reset();
        test_restart();
        do_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/comp_deser.md
Name: comp_deser

Overview:
- Receive end of the serial two's-complement link.
- Accepts a framed, LSB-first serial two's-complement word, one bit per qualified clock.
- Produces a parallel sign bit and unsigned magnitude, using the pass-until-first-one-then-invert serial complement rule internally.
- Sits after the serial complementer/link and feeds parallel arithmetic logic.

Parameters:
- WIDTH, 8, bits per serial frame, including the sign bit (MSB, last bit received); legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit, LSB first.
- x_valid  input  1  qualifies x; bits with x_valid=0 are ignored (stall).
- start  input  1  marks the first (LSB) bit of a frame; only sampled when x_valid=1.
- mag  output  WIDTH  unsigned magnitude of the received word.
- sign  output  1  1 = received word was negative.
- out_valid  output  1  one-cycle pulse; mag/sign are valid in this cycle.
- busy  output  1  1 while a frame is partially received.

Behaviour:
- Reset (async, any time):
  - mag=0, sign=0, out_valid=0, busy=0.
  - FSM=IDLE, bit counter=0, shift registers cleared.
  - A partial frame is discarded and no out_valid is produced for it.
- FSM states:
  - IDLE: no frame in progress.
  - PASS: frame active, no 1 seen yet.
  - INV: frame active, a 1 has been seen.
- Accepted bit = rising edge with x_valid=1. No state change occurs on edges with x_valid=0.
- IDLE transitions:
  - Accepted bit with start=1 starts a frame: counter=1, raw[0]=x, cpl[0]=x.
  - Next state is INV if x=1, else PASS.
  - Accepted bits with start=0 in IDLE are dropped.
- PASS/INV, bit index i = counter:
  - raw[i]=x.
  - cpl[i] = x in PASS, ~x in INV.
  - PASS→INV when x=1. INV is held until frame end.
- Frame end: the accepted bit with index WIDTH-1 (the MSB):
  - Registered on the same edge: sign=x, mag = x ? cpl : raw, using the MSB just received.
  - out_valid=1 for exactly the following cycle.
  - FSM→IDLE, counter=0.
- Latency: out_valid asserts in the cycle immediately after the MSB edge, i.e. 1 clock after the last accepted bit.
- mag/sign hold their value until the next frame end or reset.
- Back-to-back frames:
  - A start bit may be accepted in the same cycle out_valid is high; no bubble is required.
  - The new frame does not disturb mag/sign until its own frame end.
- Most negative value (-2^(WIDTH-1)): mag = 2^(WIDTH-1), sign=1. It fits because mag is unsigned WIDTH bits.
- Zero: mag=0, sign=0. FSM stays in PASS throughout and cpl equals raw.
- busy = 1 in PASS/INV, 0 in IDLE.
- start=1 on an accepted bit while busy: handled per the optional feature below.

Optional Feature:
- Macro: COMP_DESER_FRAME_ERR_EN.
- Enabled:
  - Adds output frame_err (1 bit, reset 0).
  - An accepted start=1 while busy discards the partial frame and pulses frame_err for one cycle after that edge.
  - That bit is treated as the LSB of a new frame (counter=1, FSM from x as in IDLE).
- Disabled:
  - No frame_err port.
  - start=1 while busy is ignored: the bit is taken as the next data bit of the current frame.

Test Plan (WIDTH=8, x_valid=1 unless stated):
1. After reset, frame +5, bits 1,0,1,0,0,0,0,0 with start on the first bit → out_valid pulse 1 cycle after the 8th bit; mag=5, sign=0.
2. Frame -5 (0xFB), bits 1,1,0,1,1,1,1,1 → mag=5, sign=1. Then frame 0 back-to-back, start in the out_valid cycle → mag=0, sign=0.
3. Frame -128 (0x80), bits 0,0,0,0,0,0,0,1 → mag=128, sign=1. Frame +127 → mag=127, sign=0.
4. Frame -3 (0xFD) with x_valid=0 for 3 cycles after bit 2 → result mag=3, sign=1. out_valid arrives 3 cycles later than without the stall. busy=1 throughout the stall.
5. Reset asserted after bit 4 of a frame, released, then a full +9 frame → only one out_valid pulse, with mag=9, sign=0. Outputs are 0 during reset.
6. Restart mid-frame (start=1 at bit 5, then 8 bits of -1 = 0xFF):
   - COMP_DESER_FRAME_ERR_EN defined: frame_err pulse, then mag=1, sign=1.
   - Not defined: out_valid fires after the first 8 accepted bits with values computed from those bits.
